rr_grant_encoder: RTL and testbench

//   Four-way round-robin arbiter that owns one shared resource and drives the
//   2-to-4 select decoder directly downstream of it. It emits a binary grant

---
 rtl/rr_grant_encoder_if.sv | 29 ++
 rtl/rr_grant_encoder.sv | 169 ++++++++++++++++
 tb/tb_rr_grant_encoder.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/rr_grant_encoder_if.sv
// Grant bus between the round-robin arbiter and its requesters.
// The arbiter drives the binary select and enable that feed the downstream
// 2-to-4 decoder. The requesters drive the request vector and the release strobe.
interface rr_grant_encoder_if;
    logic [3:0] req;
    logic       done;
    logic [1:0] sel;
    logic       en;
    logic       busy;
    logic       timeout;

    modport master (
        input  req,
        input  done,
        output sel,
        output en,
        output busy,
        output timeout
    );

    modport slave (
        output req,
        output done,
        input  sel,
        input  en,
        input  busy,
        input  timeout
    );
endinterface

// File: rtl/rr_grant_encoder.sv
// Four-way round-robin arbiter that drives a 2-to-4 select decoder.
// It grants one requester at a time and holds the grant until one of these happens:
//   - the requester signals done,
//   - the requester withdraws its request,
//   - the hold timer expires.
// After each grant, priority rotates to the index just past the last grant.
// Every output is registered.
module rr_grant_encoder #(
    parameter int HOLD_W   = 8,
    parameter int MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    rr_grant_encoder_if.master bus
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [HOLD_W-1:0] MAX_HOLD_C = HOLD_W'(MAX_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_SAT   = {HOLD_W{1'b1}};
    localparam logic [HOLD_W-1:0] HOLD_ONE   = HOLD_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_ZERO  = {HOLD_W{1'b0}};
    localparam logic              TO_EN      = (MAX_HOLD != 0);

    state_t            state_r;
    state_t            state_nxt_s;
    logic [1:0]        ptr_r;
    logic [1:0]        ptr_nxt_s;
    logic [HOLD_W-1:0] hold_cnt_r;
    logic [HOLD_W-1:0] hold_nxt_s;
    logic [1:0]        sel_r;
    logic [1:0]        sel_nxt_s;
    logic              en_r;
    logic              en_nxt_s;
    logic              busy_r;
    logic              timeout_r;
    logic              timeout_nxt_s;
    logic [2:0]        pick_s;
    logic              rel_done_s;
    logic              rel_wd_s;
    logic              rel_to_s;
    logic              release_s;

    // Find the first set request, scanning upward from ptr and wrapping at 4.
    // The result is {found, index}.
    function automatic logic [2:0] pick_first(input logic [3:0] r, input logic [1:0] p);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        // Walk the offsets from highest to lowest so the smallest offset wins.
        for (int i = 3; i >= 0; i--) begin
            idx = p + 2'(i);
            if (r[idx]) begin
                res = {1'b1, idx};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // Work out the arbitration pick and the three release causes.
    always_comb begin
        pick_s     = pick_first(bus.req, ptr_r);
        rel_done_s = bus.done;
        rel_wd_s   = ~bus.req[sel_r];
        rel_to_s   = TO_EN && (hold_cnt_r == MAX_HOLD_C);
        release_s  = rel_done_s | rel_wd_s | rel_to_s;
    end

    // Next-state logic. An unknown or illegal state falls back to IDLE.
    always_comb begin
        state_nxt_s = IDLE;
        case (state_r)
            IDLE: begin
                if (pick_s[2]) begin
                    state_nxt_s = GRANT;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            GRANT: begin
                if (release_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = GRANT;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Next values of the registered outputs, pointer and hold counter.
    always_comb begin
        sel_nxt_s     = sel_r;
        en_nxt_s      = 1'b0;
        timeout_nxt_s = 1'b0;
        ptr_nxt_s     = ptr_r;
        hold_nxt_s    = hold_cnt_r;
        case (state_r)
            IDLE: begin
                if (pick_s[2]) begin
                    sel_nxt_s  = pick_s[1:0];
                    en_nxt_s   = 1'b1;
                    hold_nxt_s = HOLD_ONE;
                end else begin
                    hold_nxt_s = HOLD_ZERO;
                end
            end
            GRANT: begin
                if (release_s) begin
                    en_nxt_s      = 1'b0;
                    ptr_nxt_s     = sel_r + 2'd1;
                    hold_nxt_s    = HOLD_ZERO;
                    // Flag a timeout only when the hold limit alone forced the release.
                    timeout_nxt_s = rel_to_s & ~rel_done_s & ~rel_wd_s;
                end else begin
                    en_nxt_s = 1'b1;
                    if (hold_cnt_r == HOLD_SAT) begin
                        hold_nxt_s = HOLD_SAT;
                    end else begin
                        hold_nxt_s = hold_cnt_r + HOLD_ONE;
                    end
                end
            end
            default: begin
                en_nxt_s   = 1'b0;
                hold_nxt_s = HOLD_ZERO;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Register the outputs, the priority pointer and the hold counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_r      <= 2'd0;
            en_r       <= 1'b0;
            busy_r     <= 1'b0;
            timeout_r  <= 1'b0;
            ptr_r      <= 2'd0;
            hold_cnt_r <= HOLD_ZERO;
        end else begin
            sel_r      <= sel_nxt_s;
            en_r       <= en_nxt_s;
            busy_r     <= en_nxt_s;
            timeout_r  <= timeout_nxt_s;
            ptr_r      <= ptr_nxt_s;
            hold_cnt_r <= hold_nxt_s;
        end
    end

    assign bus.sel     = sel_r;
    assign bus.en      = en_r;
    assign bus.busy    = busy_r;
    assign bus.timeout = timeout_r;

endmodule

// File: tb/tb_rr_grant_encoder.sv
// Testbench for rr_grant_encoder.
// Directed scenarios first, then randomized traffic. Every result is compared
// against a behavioural round-robin model kept in this file.
module tb_rr_grant_encoder;

    localparam int HOLD_W   = 8;
    localparam int MAX_HOLD = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    // Model of the arbiter: whether a grant is active, who holds it,
    // the priority origin and how many cycles the grant has been held.
    bit   m_granted;
    int   m_sel;
    int   m_ptr;
    int   m_hold;
    bit   m_timeout;

    rr_grant_encoder_if bus();

    rr_grant_encoder #(.HOLD_W(HOLD_W), .MAX_HOLD(MAX_HOLD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Free-running clock with a 10-unit period.
    always #5 clk = ~clk;

    // Stop the run if it is still going after the time limit.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        m_granted = 1'b0;
        m_sel     = 0;
        m_ptr     = 0;
        m_hold    = 0;
        m_timeout = 1'b0;
    endtask

    task automatic model_update(input logic [3:0] r, input logic d);
        bit a;
        bit b;
        bit c;
        m_timeout = 1'b0;
        if (!m_granted) begin
            for (int k = 0; k < 4; k++) begin
                if (r[(m_ptr + k) % 4]) begin
                    m_sel     = (m_ptr + k) % 4;
                    m_granted = 1'b1;
                    m_hold    = 1;
                    break;
                end
            end
        end else begin
            a = d;
            b = !r[m_sel];
            c = (MAX_HOLD != 0) && (m_hold == MAX_HOLD);
            if (a || b || c) begin
                m_granted = 1'b0;
                m_ptr     = (m_sel + 1) % 4;
                m_hold    = 0;
                m_timeout = c && !a && !b;
            end else if (m_hold < (1 << HOLD_W) - 1) begin
                m_hold = m_hold + 1;
            end
        end
    endtask

    // Advance one clock edge. The model sees the same inputs the DUT sampled.
    // Outputs are then sampled 1 unit after the edge.
    task automatic tick();
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_update(bus.req, bus.done);
        #1;
    endtask

    task automatic test_reset();
        bus.req = 4'd0;
        bus.done = 1'b0;
        model_reset();
        #12;
        n_cmp++; if (bus.en !== 1'b0) begin n_bad++; $display("FAIL rst_en: got %b expected %b", bus.en, 1'b0); end
        n_cmp++; if (bus.sel !== 2'd0) begin n_bad++; $display("FAIL rst_sel: got %0d expected %0d", bus.sel, 0); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b expected %b", bus.busy, 1'b0); end
        n_cmp++; if (bus.timeout !== 1'b0) begin n_bad++; $display("FAIL rst_timeout: got %b expected %b", bus.timeout, 1'b0); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick();
        n_cmp++; if (bus.en !== 1'b0) begin n_bad++; $display("FAIL rst_idle_en: got %b expected %b", bus.en, 1'b0); end
    endtask

    task automatic test_async_reset_mid_grant();
        bus.req = 4'b0100;
        tick();
        n_cmp++; if (bus.sel !== 2'd2 || bus.en !== 1'b1) begin n_bad++; $display("FAIL ar_pre: got sel=%0d en=%b expected sel=2 en=1", bus.sel, bus.en); end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (bus.en !== 1'b0) begin n_bad++; $display("FAIL ar_en: got %b expected %b", bus.en, 1'b0); end
        n_cmp++; if (bus.sel !== 2'd0) begin n_bad++; $display("FAIL ar_sel: got %0d expected %0d", bus.sel, 0); end
        n_cmp++; if (bus.timeout !== 1'b0 || bus.busy !== 1'b0) begin n_bad++; $display("FAIL ar_to_busy: got to=%b busy=%b expected 0 0", bus.timeout, bus.busy); end
        bus.req = 4'b1111;
        tick();
        rst_n = 1'b1;
        tick();
        n_cmp++; if (bus.en !== 1'b1 || bus.sel !== 2'd0) begin n_bad++; $display("FAIL ar_first: got sel=%0d en=%b expected sel=0 en=1", bus.sel, bus.en); end
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
        bus.req = 4'd0;
        tick();
    endtask

    task automatic test_single_grant();
        bus.req = 4'b0100;
        tick();
        n_cmp++; if (bus.en !== 1'b1 || bus.sel !== 2'd2) begin n_bad++; $display("FAIL sg_grant: got sel=%0d en=%b expected sel=2 en=1", bus.sel, bus.en); end
        tick();
        tick();
        n_cmp++; if (bus.en !== 1'b1 || bus.busy !== 1'b1) begin n_bad++; $display("FAIL sg_hold: got en=%b busy=%b expected 1 1", bus.en, bus.busy); end
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
        n_cmp++; if (bus.en !== 1'b0 || bus.busy !== 1'b0) begin n_bad++; $display("FAIL sg_release: got en=%b busy=%b expected 0 0", bus.en, bus.busy); end
        bus.req = 4'b1111;
        tick();
        n_cmp++; if (bus.en !== 1'b1 || bus.sel !== 2'd3) begin n_bad++; $display("FAIL sg_next_ptr: got sel=%0d en=%b expected sel=3 en=1", bus.sel, bus.en); end
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
        bus.req = 4'd0;
        tick();
    endtask

    task automatic test_rotation();
        bus.req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_cmp++; if (bus.en !== 1'b1 || bus.sel !== 2'(i % 4)) begin n_bad++; $display("FAIL rot_sel%0d: got sel=%0d en=%b expected sel=%0d en=1", i, bus.sel, bus.en, i % 4); end
            bus.done = 1'b1;
            tick();
            bus.done = 1'b0;
            n_cmp++; if (bus.en !== 1'b0) begin n_bad++; $display("FAIL rot_gap%0d: got en=%b expected 0", i, bus.en); end
        end
        bus.req = 4'd0;
        tick();
    endtask

    task automatic test_timeout();
        int cnt;
        int guard;
        bus.req = 4'b0001;
        tick();
        cnt = (bus.en === 1'b1) ? 1 : 0;
        guard = 0;
        while (bus.en === 1'b1 && guard < 40) begin
            tick();
            guard++;
            if (bus.en === 1'b1) cnt++;
        end
        n_cmp++; if (cnt != MAX_HOLD) begin n_bad++; $display("FAIL to_len: got %0d cycles expected %0d", cnt, MAX_HOLD); end
        n_cmp++; if (bus.timeout !== 1'b1 || bus.en !== 1'b0) begin n_bad++; $display("FAIL to_pulse: got to=%b en=%b expected to=1 en=0", bus.timeout, bus.en); end
        tick();
        n_cmp++; if (bus.en !== 1'b1 || bus.sel !== 2'd0 || bus.timeout !== 1'b0) begin n_bad++; $display("FAIL to_regrant: got en=%b sel=%0d to=%b expected 1 0 0", bus.en, bus.sel, bus.timeout); end
        bus.req = 4'd0;
        tick();
        n_cmp++; if (bus.en !== 1'b0 || bus.timeout !== 1'b0) begin n_bad++; $display("FAIL to_withdraw: got en=%b to=%b expected 0 0", bus.en, bus.timeout); end
    endtask

    task automatic test_done_at_timeout();
        bus.req = 4'b0001;
        tick();
        repeat (MAX_HOLD - 1) tick();
        n_cmp++; if (bus.en !== 1'b1) begin n_bad++; $display("FAIL dt_hold: got en=%b expected 1", bus.en); end
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
        n_cmp++; if (bus.en !== 1'b0 || bus.timeout !== 1'b0) begin n_bad++; $display("FAIL dt_release: got en=%b to=%b expected 0 0", bus.en, bus.timeout); end
        bus.req = 4'd0;
        tick();
    endtask

    task automatic test_withdraw();
        bus.req = 4'b0010;
        tick();
        n_cmp++; if (bus.en !== 1'b1 || bus.sel !== 2'd1) begin n_bad++; $display("FAIL wd_grant: got sel=%0d en=%b expected sel=1 en=1", bus.sel, bus.en); end
        bus.req = 4'b1001;
        tick();
        n_cmp++; if (bus.en !== 1'b0) begin n_bad++; $display("FAIL wd_drop: got en=%b expected 0", bus.en); end
        tick();
        n_cmp++; if (bus.en !== 1'b1 || bus.sel !== 2'd3) begin n_bad++; $display("FAIL wd_next: got sel=%0d en=%b expected sel=3 en=1", bus.sel, bus.en); end
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
        bus.req = 4'd0;
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 9) == 0) bus.req = 4'($urandom_range(0, 15));
            bus.done = ($urandom_range(0, 15) == 0);
            tick();
            n_cmp++; if (bus.en !== m_granted) begin n_bad++; $display("FAIL rnd_en@%0d: got %b expected %b", i, bus.en, m_granted); end
            n_cmp++; if (bus.sel !== 2'(m_sel)) begin n_bad++; $display("FAIL rnd_sel@%0d: got %0d expected %0d", i, bus.sel, m_sel); end
            n_cmp++; if (bus.busy !== m_granted) begin n_bad++; $display("FAIL rnd_busy@%0d: got %b expected %b", i, bus.busy, m_granted); end
            n_cmp++; if (bus.timeout !== m_timeout) begin n_bad++; $display("FAIL rnd_timeout@%0d: got %b expected %b", i, bus.timeout, m_timeout); end
        end
        bus.req = 4'd0;
        bus.done = 1'b0;
        tick();
    endtask

    // Run every scenario in order, then print the summary.
    initial begin
        test_reset();
        test_async_reset_mid_grant();
        test_single_grant();
        test_rotation();
        test_timeout();
        test_done_at_timeout();
        test_withdraw();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
